// File: rtl/exponent_requester.sv
// exponent_requester
//
// Host-side initiator for a single exponent accelerator. Jobs (x, a) arrive on
// a valid/ready command port and wait in a small FIFO. One job at a time is
// handed to the accelerator with a one-cycle acc_enable pulse. The result is
// captured in the single cycle it is guaranteed valid and is then offered on
// a valid/ready response port.
//
// Ports:
//   clock, reset_n          system clock, synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; cmd_ready = FIFO not full
//   cmd_x, cmd_a            base and exponent of the offered job
//   rsp_valid/rsp_ready     response handshake
//   rsp_p                   x^a mod 2^WIDTH
//   acc_enable              registered one-cycle start pulse
//   acc_x, acc_a            registered operands, held from issue to next issue
//   acc_ready, acc_p        accelerator idle/done flag and result
//   busy                    FSM not idle or jobs still queued
//   jobs_done               wrapping count of completed response handshakes
module exponent_requester #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_x,
  input  logic [WIDTH-1:0] cmd_a,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_p,
  output logic             acc_enable,
  output logic [WIDTH-1:0] acc_x,
  output logic [WIDTH-1:0] acc_a,
  input  logic             acc_ready,
  input  logic [WIDTH-1:0] acc_p,
  output logic             busy,
  output logic [CNT_W-1:0] jobs_done
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FULL_LEVEL  = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] EMPTY_LEVEL = {FILL_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_DONE = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0]  fifo_x [DEPTH];
  logic [WIDTH-1:0]  fifo_a [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FILL_W-1:0] fill;

  logic fifo_has_job;
  logic push;
  logic pop;
  logic capture;
  logic complete;

  assign cmd_ready    = (fill != FULL_LEVEL);
  assign fifo_has_job = (fill != EMPTY_LEVEL);
  assign push         = cmd_valid && cmd_ready;
  assign busy         = (state != IDLE) || fifo_has_job;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. ISSUE never looks at acc_ready: the value seen there is
  // the stale high left over from the previous job.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (fifo_has_job && acc_ready) next_state = ISSUE;
        else                           next_state = IDLE;
      end
      ISSUE: begin
        next_state = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!acc_ready) next_state = WAIT_DONE;
        else            next_state = WAIT_LOW;
      end
      WAIT_DONE: begin
        if (acc_ready) next_state = RESPOND;
        else           next_state = WAIT_DONE;
      end
      RESPOND: begin
        if (rsp_ready) next_state = IDLE;
        else           next_state = RESPOND;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode: single-cycle strobes that steer the output registers and FIFO.
  always_comb begin
    pop      = 1'b0;
    capture  = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE:      pop      = fifo_has_job && acc_ready;
      WAIT_DONE: capture  = acc_ready;  // first high cycle after the low phase
      RESPOND:   complete = rsp_ready;  // rsp_valid is always high here
      default: begin
        pop      = 1'b0;
        capture  = 1'b0;
        complete = 1'b0;
      end
    endcase
  end

  // Registered accelerator and response outputs plus the completion counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_enable <= 1'b0;
      acc_x      <= {WIDTH{1'b0}};
      acc_a      <= {WIDTH{1'b0}};
      rsp_valid  <= 1'b0;
      rsp_p      <= {WIDTH{1'b0}};
      jobs_done  <= {CNT_W{1'b0}};
    end else begin
      acc_enable <= pop;
      if (pop) begin
        acc_x <= fifo_x[rd_ptr];
        acc_a <= fifo_a[rd_ptr];
      end
      if (capture) begin
        rsp_p     <= acc_p;
        rsp_valid <= 1'b1;
      end else if (complete) begin
        rsp_valid <= 1'b0;
      end
      if (complete) begin
        jobs_done <= jobs_done + CNT_W'(1);
      end
    end
  end

  // FIFO pointers and fill level; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      fill   <= EMPTY_LEVEL;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the fill level gates every read.
  always_ff @(posedge clock) begin
    if (reset_n && push) begin
      fifo_x[wr_ptr] <= cmd_x;
      fifo_a[wr_ptr] <= cmd_a;
    end
  end

endmodule

// File: tb/tb_exponent_requester.sv
// Testbench for exponent_requester: behavioural accelerator model, response
// monitor and one task per scenario, each comparing inline against values
// computed from the rules of operation (square-and-multiply reference).
module tb_exponent_requester;

  localparam int W     = 32;
  localparam int CNT_W = 3;  // small counter so the wrap happens within the run

  logic             clock;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [W-1:0]     cmd_x;
  logic [W-1:0]     cmd_a;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_p;
  logic             acc_enable;
  logic [W-1:0]     acc_x;
  logic [W-1:0]     acc_a;
  logic             acc_ready;
  logic [W-1:0]     acc_p;
  logic             busy;
  logic [CNT_W-1:0] jobs_done;

  exponent_requester #(.WIDTH(W), .DEPTH(4), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_a(cmd_a),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
    .acc_enable(acc_enable), .acc_x(acc_x), .acc_a(acc_a),
    .acc_ready(acc_ready), .acc_p(acc_p),
    .busy(busy), .jobs_done(jobs_done)
  );

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [W-1:0] rsp_q[$];
  int           rsp_cyc_q[$];
  int           en_cyc_q[$];
  logic [W-1:0] en_x_q[$];
  logic [W-1:0] en_a_q[$];
  int           cap_q[$];
  int           en_high = 0;
  int           viol = 0;
  int           rsp_valid_seen = 0;
  int           jobs_total = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] x, input logic [W-1:0] a);
    logic [W-1:0] r;
    logic [W-1:0] b;
    r = 32'd1;
    b = x;
    for (int i = 0; i < W; i++) begin
      if (a[i]) r = r * b;
      b = b * b;
    end
    return r;
  endfunction

  // Accelerator model: low for a+2 cycles after an accepted enable, result valid
  // only in the first high cycle, garbage otherwise.
  initial begin : acc_model
    logic s_en, s_rn, s_rdy;
    logic [W-1:0] s_x, s_a, res;
    int left;
    bit fresh;
    acc_ready = 1'b1;
    acc_p = 32'd0;
    left = 0;
    fresh = 1'b0;
    res = 32'd0;
    forever begin
      @(posedge clock);
      s_en = acc_enable; s_rn = reset_n; s_rdy = acc_ready; s_x = acc_x; s_a = acc_a;
      #1;
      if (!s_rn) begin
        acc_ready = 1'b1; acc_p = $urandom; fresh = 1'b0;
      end else begin
        if (s_en) begin
          en_high++;
          if (!s_rdy) viol++;
        end
        if (s_en && s_rdy) begin
          acc_ready = 1'b0;
          left = int'(s_a) + 1;
          res = 32'd1;
          for (int i = 0; i < int'(s_a); i++) res = res * s_x;
          en_cyc_q.push_back(cyc - 1);
          en_x_q.push_back(s_x);
          en_a_q.push_back(s_a);
          acc_p = $urandom;
        end else if (!s_rdy) begin
          if (left == 0) begin
            acc_ready = 1'b1; acc_p = res; fresh = 1'b1; cap_q.push_back(cyc);
          end else begin
            left--; acc_p = $urandom;
          end
        end else if (fresh) begin
          fresh = 1'b0; acc_p = $urandom;
        end
      end
    end
  end

  // Response monitor: logs every response handshake with its cycle.
  initial begin : rsp_monitor
    forever begin
      @(negedge clock);
      if (rsp_valid === 1'b1) rsp_valid_seen++;
      if (reset_n && rsp_valid && rsp_ready) begin
        rsp_q.push_back(rsp_p);
        rsp_cyc_q.push_back(cyc);
        jobs_total++;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic clear_logs();
    rsp_q.delete(); rsp_cyc_q.delete(); en_cyc_q.delete();
    en_x_q.delete(); en_a_q.delete(); cap_q.delete();
    en_high = 0; viol = 0;
  endtask

  // Offer one command from a negedge; returns the handshake cycle or -1.
  task automatic send_cmd(input logic [W-1:0] x, input logic [W-1:0] a, output int hs);
    cmd_x = x; cmd_a = a; cmd_valid = 1'b1; hs = -1;
    for (int i = 0; i < 1000; i++) begin
      if (cmd_ready) begin
        hs = cyc;
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rsp_q.size() >= n) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b1; cmd_x = 32'd5; cmd_a = 32'd5; rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_run++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_run++; if (rsp_valid !== 1'b0 || rsp_p !== 32'd0) begin n_fail++; $display("FAIL reset_rsp: got v=%0b p=%0d want 0/0", rsp_valid, rsp_p); end
    n_run++; if (acc_enable !== 1'b0 || acc_x !== 32'd0 || acc_a !== 32'd0) begin n_fail++; $display("FAIL reset_acc: got en=%0b x=%0d a=%0d want 0", acc_enable, acc_x, acc_a); end
    n_run++; if (jobs_done !== 3'd0) begin n_fail++; $display("FAIL reset_jobs_done: got %0d want 0", jobs_done); end
    cmd_valid = 1'b0;
    reset_n = 1'b1;
    clear_logs();
    repeat (6) @(negedge clock);
    n_run++; if (busy !== 1'b0 || en_high !== 0) begin n_fail++; $display("FAIL reset_discard: got busy=%0b enables=%0d want 0/0", busy, en_high); end
  endtask

  task automatic test_single();
    int hs, first;
    clear_logs();
    rsp_ready = 1'b1;
    send_cmd(32'd3, 32'd4, hs);
    first = -1;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid === 1'b1) begin first = cyc; break; end
      @(negedge clock);
    end
    n_run++; if (first !== hs + 10) begin n_fail++; $display("FAIL single_latency: got cycle %0d want %0d", first, hs + 10); end
    n_run++; if (rsp_p !== 32'd81) begin n_fail++; $display("FAIL single_result: got %0d want 81", rsp_p); end
    @(negedge clock);
    n_run++; if (en_high !== 1 || en_x_q.size() !== 1) begin n_fail++; $display("FAIL single_enable_count: got %0d want 1", en_high); end
    else begin
      n_run++; if (en_x_q[0] !== 32'd3 || en_a_q[0] !== 32'd4) begin n_fail++; $display("FAIL single_operands: got x=%0d a=%0d want 3/4", en_x_q[0], en_a_q[0]); end
    end
    n_run++; if (jobs_done !== 3'd1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_done: got jobs=%0d v=%0b want 1/0", jobs_done, rsp_valid); end
  endtask

  task automatic test_edge();
    logic [W-1:0] xs [4];
    logic [W-1:0] as [4];
    logic [W-1:0] want [4];
    int hs;
    bit ok;
    xs = '{32'd7, 32'd0, 32'd2, 32'hFFFF_FFFF};
    as = '{32'd0, 32'd0, 32'd32, 32'd2};
    want = '{32'd1, 32'd1, 32'd0, 32'd1};
    clear_logs();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_cmd(xs[i], as[i], hs);
    wait_rsp(4, ok);
    n_run++; if (ok !== 1'b1) begin n_fail++; $display("FAIL edge_timeout: got %0d responses want 4", rsp_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_run++; if (rsp_q[i] !== want[i]) begin n_fail++; $display("FAIL edge_result_%0d: got %0h want %0h", i, rsp_q[i], want[i]); end
      end
    end
    n_run++; if (jobs_done !== CNT_W'(jobs_total)) begin n_fail++; $display("FAIL edge_jobs_done: got %0d want %0d", jobs_done, CNT_W'(jobs_total)); end
  endtask

  task automatic test_fill();
    logic [W-1:0] xs [6];
    logic [W-1:0] as [6];
    int hs [6];
    bit ok;
    clear_logs();
    rsp_ready = 1'b1;
    xs[0] = 32'd1; as[0] = 32'd200;
    for (int i = 1; i < 6; i++) begin xs[i] = $urandom; as[i] = $urandom_range(0, 6); end
    send_cmd(xs[0], as[0], hs[0]);
    for (int i = 0; i < 20 && en_cyc_q.size() == 0; i++) @(negedge clock);
    for (int i = 1; i < 5; i++) send_cmd(xs[i], as[i], hs[i]);
    n_run++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got cmd_ready=%0b want 0", cmd_ready); end
    n_run++; if (hs[4] - hs[1] !== 3) begin n_fail++; $display("FAIL fill_back_to_back: got span %0d want 3", hs[4] - hs[1]); end
    send_cmd(xs[5], as[5], hs[5]);
    wait_rsp(6, ok);
    n_run++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fill_timeout: got %0d responses want 6", rsp_q.size()); end
    else begin
      n_run++; if (hs[5] !== rsp_cyc_q[0] + 2) begin n_fail++; $display("FAIL fill_resume: got cycle %0d want %0d", hs[5], rsp_cyc_q[0] + 2); end
      for (int i = 0; i < 6; i++) begin
        n_run++; if (rsp_q[i] !== ref_pow(xs[i], as[i])) begin n_fail++; $display("FAIL fill_order_%0d: got %0h want %0h", i, rsp_q[i], ref_pow(xs[i], as[i])); end
      end
    end
    n_run++; if (viol !== 0 || en_high !== 6) begin n_fail++; $display("FAIL fill_enables: got %0d enables %0d while busy want 6/0", en_high, viol); end
  endtask

  task automatic test_backpressure();
    int hs, bad, n_en, jt;
    bit ok;
    clear_logs();
    rsp_ready = 1'b0;
    send_cmd(32'd2, 32'd10, hs);
    send_cmd(32'd2, 32'd3, hs);
    for (int i = 0; i < 60 && rsp_valid !== 1'b1; i++) @(negedge clock);
    n_en = en_cyc_q.size();
    jt = jobs_total;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid !== 1'b1 || rsp_p !== 32'd1024) bad++;
      @(negedge clock);
    end
    n_run++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    n_run++; if (n_en !== 1 || en_cyc_q.size() !== 1) begin n_fail++; $display("FAIL bp_no_issue: got %0d issues want 1", en_cyc_q.size()); end
    n_run++; if (jobs_done !== CNT_W'(jt)) begin n_fail++; $display("FAIL bp_count_stall: got %0d want %0d", jobs_done, CNT_W'(jt)); end
    @(posedge clock);
    #1 rsp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_run++; if (jobs_done !== CNT_W'(jt + 1)) begin n_fail++; $display("FAIL bp_count_once: got %0d want %0d", jobs_done, CNT_W'(jt + 1)); end
    wait_rsp(2, ok);
    n_run++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: got %0d responses want 2", rsp_q.size()); end
    else begin
      n_run++; if (rsp_q[0] !== 32'd1024 || rsp_q[1] !== 32'd8) begin n_fail++; $display("FAIL bp_results: got %0d,%0d want 1024,8", rsp_q[0], rsp_q[1]); end
    end
  endtask

  task automatic test_reset_mid();
    int hs;
    clear_logs();
    rsp_ready = 1'b1;
    send_cmd(32'd1, 32'd50, hs);
    send_cmd($urandom, 32'd3, hs);
    send_cmd($urandom, 32'd2, hs);
    repeat (5) @(negedge clock);
    n_run++; if (busy !== 1'b1 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_precondition: got busy=%0b ready=%0b want 1/1", busy, cmd_ready); end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    jobs_total = 0;
    n_run++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_idle: got busy=%0b ready=%0b want 0/1", busy, cmd_ready); end
    n_run++; if (acc_enable !== 1'b0 || acc_x !== 32'd0 || acc_a !== 32'd0 || rsp_valid !== 1'b0 || rsp_p !== 32'd0 || jobs_done !== 3'd0) begin
      n_fail++; $display("FAIL mid_outputs: got en=%0b x=%0d a=%0d v=%0b p=%0d jobs=%0d want all 0", acc_enable, acc_x, acc_a, rsp_valid, rsp_p, jobs_done);
    end
    clear_logs();
    rsp_valid_seen = 0;
    repeat (100) @(negedge clock);
    n_run++; if (rsp_valid_seen !== 0 || en_high !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_quiet: got rsp=%0d enables=%0d busy=%0b want 0/0/0", rsp_valid_seen, en_high, busy); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xs [3];
    logic [W-1:0] as [3];
    int hs;
    bit ok;
    clear_logs();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin xs[i] = $urandom; as[i] = $urandom_range(0, 8); end
    for (int i = 0; i < 3; i++) send_cmd(xs[i], as[i], hs);
    wait_rsp(3, ok);
    n_run++; if (ok !== 1'b1 || en_cyc_q.size() !== 3 || cap_q.size() !== 3) begin n_fail++; $display("FAIL b2b_timeout: got %0d responses %0d issues want 3/3", rsp_q.size(), en_cyc_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_run++; if (rsp_q[i] !== ref_pow(xs[i], as[i])) begin n_fail++; $display("FAIL b2b_result_%0d: got %0h want %0h", i, rsp_q[i], ref_pow(xs[i], as[i])); end
      end
      for (int i = 1; i < 3; i++) begin
        n_run++; if (en_cyc_q[i] - cap_q[i-1] !== 3) begin n_fail++; $display("FAIL b2b_spacing_%0d: got %0d cycles want 3", i, en_cyc_q[i] - cap_q[i-1]); end
      end
    end
    n_run++; if (viol !== 0 || en_high !== 3) begin n_fail++; $display("FAIL b2b_first_try: got %0d enables %0d rejected want 3/0", en_high, viol); end
    n_run++; if (jobs_done !== CNT_W'(jobs_total)) begin n_fail++; $display("FAIL b2b_jobs_done: got %0d want %0d", jobs_done, CNT_W'(jobs_total)); end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_x = 32'd0; cmd_a = 32'd0; rsp_ready = 1'b1; reset_n = 1'b0;
    test_reset();
    test_single();
    test_edge();
    test_fill();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
